// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default geometry.
package irq_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StService
    } irq_state_e;

    localparam int unsigned NumIrqDefault       = 3;
    localparam int unsigned DataBitsDefault     = 32;
    localparam logic [31:0] VectorBaseDefault   = 32'h0000_0800;
    localparam logic [31:0] VectorStrideDefault = 32'h0000_0040;

    // Index width that stays legal for a single request line.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set index wins; sel_valid flags any request.
module irq_priority_encoder #(
    parameter int unsigned NUM_IRQ  = 3,
    parameter int unsigned IDX_BITS = 2
) (
    input  logic [NUM_IRQ-1:0]  req,
    output logic [IDX_BITS-1:0] select,
    output logic                sel_valid
);

    always_comb begin
        select    = '0;
        sel_valid = 1'b0;
        // Scan from the top down so the lowest index is the last to overwrite.
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                select    = IDX_BITS'(i);
                sel_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller beside the PC register: edge-latched pending bits,
// software mask, per-source vectors, EPC/ERET. Define IRQ_NESTED_EN for preemption + EPC stack.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned          NUM_IRQ       = NumIrqDefault,
    parameter int unsigned          DATA_BITS     = DataBitsDefault,
    parameter logic [DATA_BITS-1:0] VECTOR_BASE   = DATA_BITS'(VectorBaseDefault),
    parameter logic [DATA_BITS-1:0] VECTOR_STRIDE = DATA_BITS'(VectorStrideDefault)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq_req,
    input  logic                 cpu_step,
    input  logic [DATA_BITS-1:0] pc_next_in,
    input  logic                 eret,
    input  logic                 mask_we,
    input  logic [NUM_IRQ-1:0]   mask_din,
    output logic                 irq_take,
    output logic [DATA_BITS-1:0] irq_vector,
    output logic                 eret_take,
    output logic [DATA_BITS-1:0] epc,
    output logic                 ie,
    output logic [NUM_IRQ-1:0]   mask,
    output logic [NUM_IRQ-1:0]   pending,
    output logic [NUM_IRQ-1:0]   in_service
);

    localparam int unsigned IdxBits = idx_bits(NUM_IRQ);

    irq_state_e           state_q;
    logic                 ie_q;
    logic [NUM_IRQ-1:0]   mask_q;
    logic [NUM_IRQ-1:0]   pending_q;
    logic [NUM_IRQ-1:0]   in_service_q;
    logic [NUM_IRQ-1:0]   req_prev_q;
    logic [DATA_BITS-1:0] epc_q;

    logic [NUM_IRQ-1:0]   req_rise;
    logic [NUM_IRQ-1:0]   masked;
    logic [NUM_IRQ-1:0]   take_onehot;
    logic [IdxBits-1:0]   select;
    logic                 sel_valid;
    logic                 take_en;
    logic                 eret_en;

    assign req_rise = irq_req & ~req_prev_q;
    assign masked   = pending_q & mask_q;

    irq_priority_encoder #(
        .NUM_IRQ  (NUM_IRQ),
        .IDX_BITS (IdxBits)
    ) u_select (
        .req       (masked),
        .select    (select),
        .sel_valid (sel_valid)
    );

    assign irq_vector = VECTOR_BASE + DATA_BITS'(select) * VECTOR_STRIDE;

`ifdef IRQ_NESTED_EN
    localparam int unsigned SpBits = $clog2(NUM_IRQ + 1);

    logic [IdxBits-1:0]   svc_idx;
    logic                 svc_valid;
    logic                 preempt;
    logic [DATA_BITS-1:0] stk_epc_q [NUM_IRQ];
    logic [NUM_IRQ-1:0]   stk_svc_q [NUM_IRQ];
    logic [SpBits-1:0]    sp_q;

    irq_priority_encoder #(
        .NUM_IRQ  (NUM_IRQ),
        .IDX_BITS (IdxBits)
    ) u_in_service (
        .req       (in_service_q),
        .select    (svc_idx),
        .sel_valid (svc_valid)
    );

    assign preempt = sel_valid & svc_valid & (select < svc_idx);
`endif

    always_comb begin
        take_en = 1'b0;
        eret_en = 1'b0;
        if (!rst && cpu_step) begin
            case (state_q)
                StIdle:    take_en = ie_q & sel_valid;
                StService: begin
                    eret_en = eret;
`ifdef IRQ_NESTED_EN
                    // A same-cycle ERET wins; the preempting source is retried afterwards.
                    take_en = ~eret & preempt;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        take_onehot = '0;
        if (take_en) begin
            take_onehot[select] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ie_q         <= 1'b1;
            mask_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            req_prev_q   <= '0;
            epc_q        <= '0;
`ifdef IRQ_NESTED_EN
            sp_q         <= '0;
`endif
        end else begin
            req_prev_q <= irq_req;
            // New edges are ORed in after the clear so set wins.
            pending_q  <= (pending_q & ~take_onehot) | req_rise;
            if (mask_we) begin
                mask_q <= mask_din;
            end
            if (take_en) begin
                epc_q        <= pc_next_in;
                in_service_q <= take_onehot;
                ie_q         <= 1'b0;
                state_q      <= StService;
`ifdef IRQ_NESTED_EN
                if (state_q == StService) begin
                    stk_epc_q[sp_q] <= epc_q;
                    stk_svc_q[sp_q] <= in_service_q;
                    sp_q            <= sp_q + 1'b1;
                end
`endif
            end else if (eret_en) begin
`ifdef IRQ_NESTED_EN
                if (sp_q != '0) begin
                    epc_q        <= stk_epc_q[sp_q - 1'b1];
                    in_service_q <= stk_svc_q[sp_q - 1'b1];
                    sp_q         <= sp_q - 1'b1;
                end else begin
                    in_service_q <= '0;
                    ie_q         <= 1'b1;
                    state_q      <= StIdle;
                end
`else
                in_service_q <= '0;
                ie_q         <= 1'b1;
                state_q      <= StIdle;
`endif
            end
        end
    end

    assign irq_take   = take_en;
    assign eret_take  = eret_en;
    assign epc        = epc_q;
    assign ie         = ie_q;
    assign mask       = mask_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: expectations queued at drive time, checked mid-cycle.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_req;
    logic        cpu_step;
    logic [31:0] pc_next_in;
    logic        eret;
    logic        mask_we;
    logic [2:0]  mask_din;
    logic        irq_take;
    logic [31:0] irq_vector;
    logic        eret_take;
    logic [31:0] epc;
    logic        ie;
    logic [2:0]  mask;
    logic [2:0]  pending;
    logic [2:0]  in_service;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    irq_controller u_dut (
        .clk        (clk),
        .rst        (rst),
        .irq_req    (irq_req),
        .cpu_step   (cpu_step),
        .pc_next_in (pc_next_in),
        .eret       (eret),
        .mask_we    (mask_we),
        .mask_din   (mask_din),
        .irq_take   (irq_take),
        .irq_vector (irq_vector),
        .eret_take  (eret_take),
        .epc        (epc),
        .ie         (ie),
        .mask       (mask),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; irq_req = '0; cpu_step = 1'b0; pc_next_in = '0;
        eret = 1'b0; mask_we = 1'b0; mask_din = '0;
        next(); next();
        // Takes are gated off during reset even with eret asserted.
        eret = 1'b1; cpu_step = 1'b1;
        exp("rst_irq_take", 0); exp("rst_eret_take", 0);
        mid(); chk(irq_take); chk(eret_take);
        next();
        rst = 1'b0; eret = 1'b0; cpu_step = 1'b0;
        exp("rst_ie", 1); exp("rst_mask", 0); exp("rst_pending", 0);
        exp("rst_in_service", 0); exp("rst_epc", 0);
        mid(); chk(ie); chk(mask); chk(pending); chk(in_service); chk(epc);

        // 1: single request on source 1
        mask_we = 1'b1; mask_din = 3'b111;
        next();
        mask_we = 1'b0; irq_req = 3'b010; cpu_step = 1'b1; pc_next_in = 32'h24;
        exp("t1_no_take_same_cycle", 0);
        mid(); chk(irq_take);
        next();
        irq_req = 3'b000;
        exp("t1_pending", 3'b010); exp("t1_take", 1); exp("t1_vector", 32'h840);
        mid(); chk(pending); chk(irq_take); chk(irq_vector);
        next();
        // 2: simultaneous sources 0 and 2 while source 1 is in service
        irq_req = 3'b101;
        exp("t1_epc", 32'h24); exp("t1_ie", 0); exp("t1_in_service", 3'b010);
        exp("t1_pending_clr", 0); exp("t1_svc_no_take", 0);
        mid(); chk(epc); chk(ie); chk(in_service); chk(pending); chk(irq_take);
        next();
        irq_req = 3'b000; eret = 1'b1;
        exp("t2_eret_take", 1); exp("t2_ret_epc", 32'h24);
        mid(); chk(eret_take); chk(epc);
        next();
        eret = 1'b0; pc_next_in = 32'h30;
        exp("t2_ie_back", 1); exp("t2_take0", 1); exp("t2_vec0", 32'h800);
        mid(); chk(ie); chk(irq_take); chk(irq_vector);
        next();
        eret = 1'b1;
        exp("t2_in_service0", 3'b001); exp("t2_pending_left", 3'b100); exp("t2_eret2", 1);
        mid(); chk(in_service); chk(pending); chk(eret_take);
        next();
        eret = 1'b0;
        exp("t2_take2", 1); exp("t2_vec2", 32'h880);
        mid(); chk(irq_take); chk(irq_vector);
        next();
        eret = 1'b1;
        mid();
        next();
        eret = 1'b0;

        // 3: masked request, then unmask (old mask used in the write cycle)
        mask_we = 1'b1; mask_din = 3'b000;
        next();
        mask_we = 1'b0; irq_req = 3'b100;
        next();
        irq_req = 3'b000; mask_we = 1'b1; mask_din = 3'b100;
        exp("t3_pending", 3'b100); exp("t3_masked_no_take", 0);
        mid(); chk(pending); chk(irq_take);
        next();
        mask_we = 1'b0;
        exp("t3_mask", 3'b100); exp("t3_take_after_write", 1); exp("t3_vec", 32'h880);
        mid(); chk(mask); chk(irq_take); chk(irq_vector);
        next();
        // mask write while in service
        eret = 1'b1; mask_we = 1'b1; mask_din = 3'b111;
        next();
        eret = 1'b0; mask_we = 1'b0;

        // 4: halted core, then a long-held level
        irq_req = 3'b010; cpu_step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp("t4_halt_no_take", 0);
            mid(); chk(irq_take);
            next();
        end
        cpu_step = 1'b1;
        exp("t4_take_on_step", 1); exp("t4_vec", 32'h840);
        mid(); chk(irq_take); chk(irq_vector);
        next();
        eret = 1'b1;
        exp("t4_held_no_retrigger", 0);
        mid(); chk(pending);
        next();
        eret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp("t4_held_pending", 0); exp("t4_held_no_take", 0);
            mid(); chk(pending); chk(irq_take);
            next();
        end
        irq_req = 3'b000;

        // 5a: eret in IDLE is ignored
        eret = 1'b1;
        exp("t5_idle_eret", 0);
        mid(); chk(eret_take);
        next();
        eret = 1'b0;
        exp("t5_idle_ie", 1); exp("t5_idle_svc", 0);
        mid(); chk(ie); chk(in_service);

        // 6: higher-priority request while source 2 is in service
        irq_req = 3'b100; pc_next_in = 32'h24;
        next();
        irq_req = 3'b000;
        exp("t6_take2", 1); exp("t6_vec2", 32'h880);
        mid(); chk(irq_take); chk(irq_vector);
        next();
        irq_req = 3'b001; pc_next_in = 32'h810;
        exp("t6_epc", 32'h24); exp("t6_svc2", 3'b100);
        mid(); chk(epc); chk(in_service);
        next();
        irq_req = 3'b000;
`ifdef IRQ_NESTED_EN
        exp("t6_preempt", 1); exp("t6_pre_vec", 32'h800);
        mid(); chk(irq_take); chk(irq_vector);
        next();
        eret = 1'b1;
        exp("t6_pre_epc", 32'h810); exp("t6_pre_svc", 3'b001); exp("t6_eret1", 1);
        mid(); chk(epc); chk(in_service); chk(eret_take);
        next();
        exp("t6_pop_epc", 32'h24); exp("t6_pop_svc", 3'b100);
        exp("t6_still_svc_ie", 0); exp("t6_eret2", 1);
        mid(); chk(epc); chk(in_service); chk(ie); chk(eret_take);
        next();
`else
        eret = 1'b1;
        exp("t6_no_preempt", 0); exp("t6_pending0", 3'b001); exp("t6_eret", 1);
        mid(); chk(irq_take); chk(pending); chk(eret_take);
        next();
        eret = 1'b0; pc_next_in = 32'h24;
        exp("t6_late_take", 1); exp("t6_late_vec", 32'h800);
        mid(); chk(irq_take); chk(irq_vector);
        next();
        eret = 1'b1;
        exp("t6_late_svc", 3'b001);
        mid(); chk(in_service);
        next();
`endif
        eret = 1'b0;
        exp("t6_idle_ie", 1); exp("t6_idle_svc", 0);
        mid(); chk(ie); chk(in_service);

        // 5b: reset in the middle of a handler
        irq_req = 3'b001; pc_next_in = 32'h100;
        next();
        irq_req = 3'b000;
        next();
        exp("t5_svc_epc", 32'h100); exp("t5_svc_ie", 0);
        mid(); chk(epc); chk(ie);
        next();
        rst = 1'b1; eret = 1'b1;
        exp("t5_rst_eret_gated", 0);
        mid(); chk(eret_take);
        next();
        rst = 1'b0;
        exp("t5_rst_idle_eret", 0); exp("t5_rst_ie", 1); exp("t5_rst_mask", 0);
        exp("t5_rst_epc", 0); exp("t5_rst_svc", 0);
        mid(); chk(eret_take); chk(ie); chk(mask); chk(epc); chk(in_service);
        next();
        eret = 1'b0;

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller for the single-cycle MIPS core.
- Latches external request edges (debounced buttons, timer tick) into sticky pending bits, applies a software mask, and redirects the PC to a per-source handler vector at an instruction boundary.
- Saves the return address in EPC and restores it on ERET.
- Sits beside the PC register: its redirect and vector outputs feed the next-PC mux ahead of the normal pc_next.

Parameters:
NUM_IRQ, 3, number of request lines; index 0 = highest priority
DATA_BITS, 32, PC/EPC width
VECTOR_BASE, 32'h0000_0800, handler address of source 0
VECTOR_STRIDE, 32'h0000_0040, byte spacing between consecutive handler vectors

Ports:
clk  in  1  core clock (clk_N domain)
rst  in  1  reset; synchronous, active-high
irq_req  in  NUM_IRQ  request lines, already synchronised; rising edge = request
cpu_step  in  1  current instruction retires this cycle (pcen)
pc_next_in  in  DATA_BITS  datapath next-PC of the retiring instruction
eret  in  1  current instruction decodes as ERET
mask_we  in  1  write the mask register this cycle
mask_din  in  NUM_IRQ  new mask value; 1 = enabled
irq_take  out  1  redirect PC to irq_vector this cycle
irq_vector  out  DATA_BITS  handler address of the selected source
eret_take  out  1  redirect PC to epc this cycle
epc  out  DATA_BITS  saved return address
ie  out  1  global interrupt enable
mask  out  NUM_IRQ  mask register
pending  out  NUM_IRQ  sticky pending bits
in_service  out  NUM_IRQ  one-hot source being serviced

Behaviour:
- Reset values (on clk edge with rst=1): state IDLE, ie=1, mask=0, pending=0, in_service=0, epc=0, edge-detect history=0.
  - irq_take and eret_take are combinational; both read 0 while in reset.
  - Reset during SERVICE abandons the handler without restoring the PC.
- Edge detect:
  - pending[i] sets on the cycle after irq_req[i] goes 0->1.
  - A held high level does not re-trigger.
  - Set wins over a same-cycle clear.
- select = lowest index in (pending & mask); sel_valid = |(pending & mask).
- irq_vector = VECTOR_BASE + select*VECTOR_STRIDE (combinational, modulo 2^DATA_BITS).
- States:
  - IDLE:
    - irq_take = ie & sel_valid & cpu_step.
    - On the edge where irq_take=1: epc<=pc_next_in; pending[select]<=0; in_service<=onehot(select); ie<=0; ->SERVICE.
    - eret in IDLE is ignored (eret_take=0; the PC advances normally).
  - SERVICE:
    - irq_take=0 (non-nested build).
    - eret_take = eret & cpu_step.
    - On that edge: in_service<=0; ie<=1; ->IDLE.
    - New requests still latch into pending.
- cpu_step=0 (syscall halt): no take, no return; pending keeps accumulating.
- mask_we writes mask in any state. Take evaluation in the same cycle uses the old mask; the new mask applies from the next cycle.
- Latency: request edge -> earliest irq_take is 1 cycle.

Optional Feature:
IRQ_NESTED_EN
- Defined:
  - In SERVICE, a selected source with index lower than the in-service index preempts: irq_take=1.
  - On preemption, push {epc, in_service} onto an NUM_IRQ-deep stack, then load the new EPC and in_service.
  - eret pops the stack; ie returns to 1 and state returns to IDLE only when the stack is empty.
  - Equal or lower priority sources wait.
- Undefined: no preemption and no stack, as described above.

Decomposition:
- Package irq_pkg: state encoding (IDLE, SERVICE), default NUM_IRQ, VECTOR_BASE and VECTOR_STRIDE constants.
- One sub-module, irq_priority_encoder: NUM_IRQ-wide request in, select index plus sel_valid out, purely combinational; reused for the preemption compare.

Test Plan:
1. Reset; mask_we with mask_din=3'b111; pulse irq_req[1]; cpu_step=1, pc_next_in=0x24 -> pending=3'b010 next cycle, then irq_take=1 with irq_vector=0x840; after the edge: epc=0x24, ie=0, in_service=3'b010, pending=0.
2. irq_req[0] and irq_req[2] rise together -> vector 0x800 taken first; eret with cpu_step=1 -> eret_take=1, ie=1; next cycle irq_take with vector 0x880.
3. mask=3'b000; pulse irq_req[2] -> pending=3'b100, no take; write mask=3'b100 -> irq_take the cycle after the write.
4. Pending with cpu_step=0 for 5 cycles -> irq_take=0 throughout; cpu_step=1 -> take the same cycle. Hold irq_req[1] high for 10 cycles -> exactly one pending set.
5. eret in IDLE -> eret_take=0, no state change. rst=1 during SERVICE -> next cycle state IDLE, ie=1, mask=0, epc=0.
6. (IRQ_NESTED_EN) Servicing source 2 at epc=0x24; irq_req[0] at pc_next_in=0x810 -> take 0x800, epc=0x810. First eret -> return to 0x810, still SERVICE. Second eret -> return to 0x24, IDLE.
